fifo_byte_serializer: RTL and testbench

Downstream drain stage for the 32-bit, 8-deep FIFO. It pops one word at a time through the FIFO read port and serialises each word into four bytes on a valid/ready byte stream. The FIFO's registered read latency (data one cycle after `rd`) is absorbed internally. It also keeps a running count of words fully transmitted.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_byte_serializer.sv | 121 ++++++++++++
 tb/tb_fifo_byte_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 32-bit x 8 FIFO and its byte-serialising drain stage.
package fifo_pkg;

  localparam int FIFO_DATA_W    = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int FIFO_DEPTH     = 8;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Drains the FIFO one word at a time and presents each word as four bytes on a
// valid/ready stream, prefetching the next word on the last-byte handshake.
module fifo_byte_serializer
  import fifo_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [FIFO_DATA_W-1:0] fifo_data,
  output logic                   fifo_rd,
  output logic [BYTE_W-1:0]      byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   byte_last,
  output logic                   busy,
  output logic [CNT_W-1:0]       words_sent
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FIFO_DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rd_s;

  // Byte position idx counts transmission order; map it onto the word lanes.
  function automatic logic [BYTE_W-1:0] select_byte(
    input logic [FIFO_DATA_W-1:0] word,
    input logic [IDX_W-1:0]       idx
  );
    logic [IDX_W-1:0] lane;
    lane = LSB_FIRST ? idx : (LAST_IDX - idx);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

  // Next-state, datapath and stream outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    rd_s       = 1'b0;
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    byte_last  = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        rd_s = !fifo_empty;
        if (!fifo_empty) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        word_d  = fifo_data;
        idx_d   = '0;
        state_d = SEND;
      end

      SEND: begin
        byte_valid = 1'b1;
        byte_out   = select_byte(word_q, idx_q);
        byte_last  = (idx_q == LAST_IDX);
        if (byte_ready) begin
          if (idx_q == LAST_IDX) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            // Prefetch on the final handshake so the next word loads without an idle cycle.
            if (!fifo_empty) begin
              rd_s    = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, byte index, word buffer and completed-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // The read strobe is combinational, so mask it directly while reset is held.
  assign fifo_rd    = rd_s & reset;
  assign words_sent = cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench: a queue-based FIFO model feeds an LSB-first and an MSB-first
// (3-bit counter) instance; expected bytes are queued at push time and popped per handshake.
module tb_fifo_byte_serializer;

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic        byte_ready;
  logic [31:0] fifo_data;

  logic        rd0, bv0, bl0, busy0;
  logic [7:0]  bo0;
  logic [15:0] ws0;
  logic        rd1, bv1, bl1, busy1;
  logic [7:0]  bo1;
  logic [2:0]  ws1;

  logic [31:0] fq[$];
  logic [7:0]  e0[$];
  logic [7:0]  e1[$];
  int          hs[$];
  int          rd_cycles[$];
  int          cyc;
  int          exp_words;
  int          n_chk;
  int          n_pass;
  logic        held;
  logic [7:0]  held_byte;
  logic        held_last;

  fifo_byte_serializer #(.LSB_FIRST(1'b1), .CNT_W(16)) u_lsb (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(rd0), .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready),
    .byte_last(bl0), .busy(busy0), .words_sent(ws0)
  );

  fifo_byte_serializer #(.LSB_FIRST(1'b0), .CNT_W(3)) u_msb (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(rd1), .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready),
    .byte_last(bl1), .busy(busy1), .words_sent(ws1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e0.push_back(w[8*i +: 8]);
      e1.push_back(w[8*(3-i) +: 8]);
    end
  endtask

  task automatic monitor();
    logic       exp_rd;
    logic [7:0] b;
    logic       last;
    exp_rd = reset && !fifo_empty && (!busy0 || (bv0 && bl0 && byte_ready));
    check("fifo_rd", 32'(rd0), 32'(exp_rd));
    if (rd0) rd_cycles.push_back(cyc);
    if (!bv0) check("byte_out_idle", 32'(bo0), 32'h0);
    if (held) begin
      check("stall_valid", 32'(bv0), 32'h1);
      check("stall_byte", 32'(bo0), 32'(held_byte));
      check("stall_last", 32'(bl0), 32'(held_last));
    end
    held      = bv0 && !byte_ready;
    held_byte = bo0;
    held_last = bl0;
    if (bv0 && byte_ready) begin
      hs.push_back(cyc);
      if (e0.size() == 0 || e1.size() == 0) begin
        check("byte_unexpected", 32'(bv0), 32'h0);
      end else begin
        b    = e0.pop_front();
        last = (e0.size() % 4 == 0);
        check("lsb_byte", 32'(bo0), 32'(b));
        check("lsb_last", 32'(bl0), 32'(last));
        check("lsb_words", 32'(ws0), 32'(exp_words % 65536));
        b = e1.pop_front();
        check("msb_byte", 32'(bo1), 32'(b));
        check("msb_last", 32'(bl1), 32'(last));
        check("msb_words", 32'(ws1), 32'(exp_words % 8));
        if (last) exp_words++;
      end
    end
  endtask

  // One clock: observe at the falling edge, then model the registered FIFO read.
  task automatic step();
    logic rd;
    @(negedge clk);
    monitor();
    rd = rd0;
    @(posedge clk);
    cyc++;
    #1;
    if (rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; exp_words = 0; held = 1'b0;
    held_byte = 8'h00; held_last = 1'b0;
    reset = 1'b0; fifo_empty = 1'b1; byte_ready = 1'b0; fifo_data = 32'h0;

    // Reset held with a word waiting: everything must stay quiet.
    push_word(32'h44332211);
    repeat (3) step();
    check("rst_rd", 32'(rd0), 32'h0);
    check("rst_valid", 32'(bv0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_byte", 32'(bo0), 32'h0);
    check("rst_last", 32'(bl0), 32'h0);
    check("rst_words", 32'(ws0), 32'h0);

    // Single word, ready held high.
    reset = 1'b1; byte_ready = 1'b1;
    #1;
    check("rd_after_release", 32'(rd0), 32'h1);
    repeat (8) step();
    check("t1_drain", 32'(e0.size()), 32'h0);
    check("t1_hs_count", 32'(hs.size()), 32'd4);
    if (hs.size() == 4 && rd_cycles.size() > 0) begin
      check("t1_latency", 32'(hs[0] - rd_cycles[0]), 32'd2);
      check("t1_burst", 32'(hs[3] - hs[0]), 32'd3);
    end
    check("t1_words_lsb", 32'(ws0), 32'd1);
    check("t1_words_msb", 32'(ws1), 32'd1);

    // Two queued words: prefetch on the last byte, one LOAD gap.
    hs.delete(); rd_cycles.delete();
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    repeat (14) step();
    check("t3_drain", 32'(e0.size()), 32'h0);
    check("t3_hs_count", 32'(hs.size()), 32'd8);
    check("t3_rd_count", 32'(rd_cycles.size()), 32'd2);
    if (hs.size() == 8 && rd_cycles.size() == 2) begin
      check("t3_prefetch_cycle", 32'(rd_cycles[1]), 32'(hs[3]));
      check("t3_gap", 32'(hs[4] - hs[3]), 32'd2);
      check("t3_rate", 32'(hs[7] - hs[3]), 32'd5);
    end
    check("t3_words", 32'(ws0), 32'd3);

    // Backpressure pattern 1,0,0,1,...
    hs.delete();
    push_word(32'hDEADBEEF);
    push_word(32'h0BADF00D);
    for (int i = 0; i < 40; i++) begin
      byte_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    byte_ready = 1'b1;
    check("t4_drain", 32'(e0.size()), 32'h0);
    check("t4_hs_count", 32'(hs.size()), 32'd8);
    check("t4_words", 32'(ws0), 32'd5);

    // Empty FIFO: nothing happens regardless of ready.
    for (int i = 0; i < 10; i++) begin
      byte_ready = 1'($urandom_range(0, 1));
      step();
      check("t5_busy", 32'(busy0), 32'h0);
      check("t5_valid", 32'(bv0), 32'h0);
      check("t5_rd", 32'(rd0), 32'h0);
    end

    // Five more words: the 3-bit counter wraps past 7.
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(32'h10203040 + 32'(i) * 32'h01010101);
    repeat (30) step();
    check("t6_drain", 32'(e0.size()), 32'h0);
    check("t6_words_lsb", 32'(ws0), 32'd10);
    check("t6_words_wrap", 32'(ws1), 32'd2);

    // Reset mid-word after two bytes; the next word must go out whole.
    hs.delete();
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    for (int i = 0; i < 20 && hs.size() < 2; i++) step();
    check("t7_reached", 32'(hs.size()), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t7_rd", 32'(rd0), 32'h0);
    check("t7_valid", 32'(bv0), 32'h0);
    check("t7_byte", 32'(bo0), 32'h0);
    check("t7_last", 32'(bl0), 32'h0);
    check("t7_busy", 32'(busy0), 32'h0);
    check("t7_words_lsb", 32'(ws0), 32'h0);
    check("t7_words_msb", 32'(ws1), 32'h0);
    repeat (e0.size() % 4) void'(e0.pop_front());
    repeat (e1.size() % 4) void'(e1.pop_front());
    exp_words = 0;
    held      = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (10) step();
    check("t7_drain", 32'(e0.size()), 32'h0);
    check("t7_words_after", 32'(ws0), 32'd1);
    check("t7_words_after_msb", 32'(ws1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
